// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// ----------------
// Asynchronous 8N1 UART receiver feeding the Peripheral UART register set.
// The raw line is brought into the clk domain through a two-flop
// synchroniser. A start bit is qualified at mid-bit, 8 data bits are sampled
// LSB first at mid-bit, and the stop bit is checked at mid-stop. A good byte
// is handed over with a valid/ack handshake. Error flags are sticky and are
// cleared by rx_ack.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected between data bit 7 and the
//   stop bit. The frame is then 11 bits long and the parity_err port exists.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   UART_RX    in   raw serial line, idles high, asynchronous to clk
//   rx_ack     in   one-cycle pulse when the RX data register is read
//   rx_data    out  [7:0] last accepted byte
//   rx_valid   out  rx_data holds an unread byte
//   rx_busy    out  a frame is in progress
//   frame_err  out  sticky, a stop bit was sampled low
//   overrun    out  sticky, a byte completed while rx_valid was already 1
//   parity_err out  sticky, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic          shift_en;
  logic          stop_tick;
  logic [7:0]    shift;

  logic          sync_p0, sync_p1, rxs_p2;
  logic          vld_p0, vld_p1;
  logic          armed;
  logic          rxs;
  logic          fall;

  logic [7:0]    byte_p0;
  logic          good_vld_p0;
  logic          ferr_vld_p0;

`ifdef UART_RX_PARITY_EN
  logic          par_tick;
  logic          par_bad;
  logic          perr_vld_p0;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~^{d, p};
  endfunction
`endif

  assign rxs     = sync_p1;
  assign fall    = armed && rxs_p2 && !rxs;
  assign rx_busy = (state != IDLE);

  // ---- stage p0/p1: synchroniser, p2: previous synchronised sample ----
  // vld_pN marks when the synchroniser holds real line data rather than the
  // reset preset, so a line held low through reset is not mistaken for a
  // falling edge. armed goes high once the real line has been seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      rxs_p2  <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync_p0 <= UART_RX;
      sync_p1 <= sync_p0;
      rxs_p2  <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      if (vld_p1 && sync_p1) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_en   = 1'b0;
    stop_tick  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_tick   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (fall) begin
          state_nx = START;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rxs ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          par_tick = 1'b1;
          state_nx = STOP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx    = '0;
          stop_tick = 1'b1;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift[bit_idx] <= rxs;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad <= 1'b0;
    end else if (par_tick) begin
      par_bad <= !even_parity_ok(shift, rxs);
    end
  end
`endif

  // ---- stage p0: stop-bit sample registered as frame outcome ----
  always_ff @(posedge clk) begin
    if (reset) begin
      good_vld_p0 <= 1'b0;
      ferr_vld_p0 <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_vld_p0 <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_PARITY_EN
      good_vld_p0 <= stop_tick && rxs && !par_bad;
      perr_vld_p0 <= stop_tick && par_bad;
`else
      good_vld_p0 <= stop_tick && rxs;
`endif
      ferr_vld_p0 <= stop_tick && !rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (stop_tick) begin
      byte_p0 <= shift;
    end
  end

  // ---- output stage: delivery and sticky flags ----
  // rx_ack clears first; a same-cycle delivery or error then overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (good_vld_p0) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= byte_p0;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (ferr_vld_p0) begin
        frame_err <= 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (perr_vld_p0) begin
        parity_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Asynchronous UART receiver sitting directly upstream of the Peripheral block's UART register set.
- Synchronises the raw UART_RX pin, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit and presents a received byte with a valid/ack handshake.
- The Peripheral read path consumes rx_data/rx_valid for the UART RX data register (0x4000001c) and the flags for the UART control/status register (0x40000020).

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (9600 baud at 50 MHz); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2, sample offset from the start-bit falling edge to mid-start.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- UART_RX  input  1  raw serial line; idles high; asynchronous to clk.
- rx_ack  input  1  one-cycle pulse from Peripheral when the RX data register is read.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte completed while rx_valid was already 1.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and all counters clear.
  - rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - The synchroniser flops preset to 1.
- Synchroniser: two flops, rxs = UART_RX delayed 2 cycles. All FSM decisions use rxs only.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - When rxs=0 (and the previous rxs=1, i.e. a falling edge), go to START and clear the clk counter.
  - A line held low from reset does not start a frame until a 1->0 edge is seen.
- START:
  - Count to HALF_BIT-1, then sample rxs.
  - If rxs=0, go to DATA with the clk counter and bit index cleared.
  - If rxs=1 (glitch), return to IDLE with no flag changes.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into shift[bit_idx], LSB first.
  - After bit 7 is sampled, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rxs, then return to IDLE in the same edge. This is mid-stop, so back-to-back frames with a single stop bit are received.
  - rxs=1: the frame is good and is delivered (see Delivery).
  - rxs=0: set frame_err; the byte is discarded and rx_data/rx_valid are unchanged.
- Delivery, on the edge after the stop sample:
  - If rx_valid=0, or rx_ack is high in the same cycle: rx_data <= byte, rx_valid <= 1, overrun unchanged.
  - Otherwise the new byte is discarded, rx_data is kept, and overrun <= 1.
- rx_ack:
  - rx_ack=1 clears rx_valid, frame_err and overrun on the next edge, unless a good delivery occurs in that same cycle; delivery wins for rx_valid.
  - rx_ack while rx_valid=0 has no effect apart from clearing flags.
- Latency: rx_valid rises 2 (synchroniser) + 1 cycles after the stop-bit mid-point reaches the pin, i.e. about 9.5 bit periods after the start edge.
- rx_busy is high in START, DATA and STOP.
- Counter widths: clk counter is $clog2(CLKS_PER_BIT) bits and must never wrap inside a bit; bit_idx is 3 bits.
- Reset asserted mid-frame aborts the frame immediately with no delivery and no flags. Reception resumes only on the next falling edge after reset deasserts.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is expected between bit 7 and the stop bit; add a PARITY state sampled at mid-bit.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by rx_ack).
  - On mismatch, set parity_err and discard the byte; the stop bit is still checked.
  - Frame is 11 bits.
- Undefined: no PARITY state and no parity_err port; 10-bit frame.

Test Plan:
- CLKS_PER_BIT=16, reset held 5 cycles, then the line idles high -> all outputs 0, rx_busy=0.
- Send 0x96 (start 0, bits 0,1,1,0,1,0,0,1, stop 1) -> rx_data=8'h96, rx_valid=1 at 3 cycles after the stop mid-point; pulse rx_ack -> rx_valid=0 next cycle.
- Send 0xA7 then 0xFF back-to-back with no ack -> rx_data stays 8'hA7, overrun=1; rx_ack clears both rx_valid and overrun.
- Send 0x55 with stop bit 0 -> frame_err=1, rx_valid unchanged (0), rx_data unchanged.
- Pulse UART_RX low for 4 cycles (shorter than HALF_BIT) -> returns to IDLE, rx_busy drops by cycle ~10, no flags, no data.
- Assert reset at the DATA bit-3 midpoint of 0x96, release it, then send 0x3C -> no 0x96 delivery, rx_data=8'h3C.
- With UART_RX_PARITY_EN defined, sending 0x96 with parity 1 -> parity_err=1, no delivery.
